// File: rtl/gs_div_if.sv
// Request/result handshake bundle for the Goldschmidt divider.
// slave  : the divider engine side.
// master : the request source / result consumer side.
interface gs_div_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_dz;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_n, in_d, out_ready,
    output in_ready, out_valid, out_q, out_dz, out_ovf
  );

  modport master (
    output in_valid, in_n, in_d, out_ready,
    input  in_ready, out_valid, out_q, out_dz, out_ovf
  );
endinterface

// File: rtl/gs_div_iter.sv
// Sequential Goldschmidt divider, Q = N / D, unsigned fixed point with FRAC
// fractional bits. One division in flight; the reciprocal seed comes from an
// external combinational table (seed_d -> seed_f).
// Optional build macro: GS_EARLY_EXIT_EN -- leave the iteration loop as soon
// as the refined divisor reaches exactly 1.0.
module gs_div_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ITERS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  gs_div_if.slave          bus,
  output logic [WIDTH-1:0] seed_d,
  input  logic [WIDTH-1:0] seed_f
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(1) << (FRAC + 1);
  localparam logic [3:0]       LAST = 4'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Fixed-point multiply: keep the WIDTH bits above the fraction, saturate to
  // all ones when anything above them is set. Returns {saturated, value}.
  function automatic logic [WIDTH:0] mul_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    logic               hi;
    p  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    hi = (p >> (FRAC + WIDTH)) != '0;
    if (hi) mul_sat = {1'b1, {WIDTH{1'b1}}};
    else    mul_sat = {1'b0, WIDTH'(p >> FRAC)};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] f_r;
  logic [3:0]       count;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_q_r;
  logic             out_dz_r;
  logic             out_ovf_r;

  logic [WIDTH:0]   n_prod;
  logic [WIDTH:0]   d_prod;
  logic [WIDTH-1:0] n_new;
  logic [WIDTH-1:0] d_new;
  logic             last_iter;

  assign n_prod = mul_sat(n_r, f_r);
  assign d_prod = mul_sat(d_r, f_r);
  assign n_new  = n_prod[WIDTH-1:0];
  assign d_new  = d_prod[WIDTH-1:0];

`ifdef GS_EARLY_EXIT_EN
  assign last_iter = (count == LAST) || (d_new == ONE);
`else
  assign last_iter = (count == LAST);
`endif

  assign seed_d        = d_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_dz    = out_dz_r;
  assign bus.out_ovf   = out_ovf_r;

  // Control FSM and operand registers; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_r         <= '0;
      d_r         <= '0;
      f_r         <= '0;
      count       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_q_r     <= '0;
      out_dz_r    <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            n_r        <= bus.in_n;
            d_r        <= bus.in_d;
            count      <= '0;
            out_dz_r   <= 1'b0;
            out_ovf_r  <= 1'b0;
            if (bus.in_d == '0) begin
              // Zero divisor: skip the table and iterations entirely.
              out_q_r     <= '1;
              out_dz_r    <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              state <= SEED;
            end
          end
        end
        SEED: begin
          // seed_d has shown the captured divisor for a full cycle by now.
          f_r   <= seed_f;
          state <= MUL;
        end
        MUL: begin
          n_r       <= n_new;
          d_r       <= d_new;
          f_r       <= TWO - d_new;
          count     <= count + 4'd1;
          out_ovf_r <= out_ovf_r | n_prod[WIDTH] | d_prod[WIDTH];
          if (last_iter) begin
            out_q_r     <= n_new;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_div_iter.sv
// Directed bench for gs_div_iter (Q8.8, ITERS=4). The bench plays both the
// request source and the seed table (seed_f driven per test).
module tb_gs_div_iter;

`ifdef GS_EARLY_EXIT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] seed_d;
  logic [15:0] seed_f = '0;
  int          checks = 0;
  int          errors = 0;

  gs_div_if #(.WIDTH(16)) bus ();

  gs_div_iter #(.WIDTH(16), .FRAC(8), .ITERS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .seed_d (seed_d),
    .seed_f (seed_f)
  );

  always #5 clk = ~clk;

  // Issue one request (called #1 after a rising edge with in_ready high) and
  // wait for out_valid; lat = cycles from accept to out_valid (40 = timeout).
  task automatic do_div(input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] f, output int lat);
    bus.in_n     = n;
    bus.in_d     = d;
    seed_f       = f;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_q !== 16'h0000) begin errors++; $display("FAIL rst_out_q got %h want 0000", bus.out_q); end
    checks++; if (bus.out_dz !== 1'b0) begin errors++; $display("FAIL rst_out_dz got %b want 0", bus.out_dz); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got %b want 0", bus.out_ovf); end
    checks++; if (seed_d !== 16'h0000) begin errors++; $display("FAIL rst_seed_d got %h want 0000", seed_d); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    int lat;
    do_div(16'h0600, 16'h0200, 16'h0080, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL exact_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (bus.out_q !== 16'h0300) begin errors++; $display("FAIL exact_q got %h want 0300", bus.out_q); end
    checks++; if (bus.out_dz !== 1'b0) begin errors++; $display("FAIL exact_dz got %b want 0", bus.out_dz); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL exact_ovf got %b want 0", bus.out_ovf); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL exact_in_ready got %b want 0", bus.in_ready); end
    checks++; if (seed_d !== 16'h0100) begin errors++; $display("FAIL exact_seed_d got %h want 0100", seed_d); end
    consume();
  endtask

  task automatic test_refine();
    int lat;
    // 1.0 / 3.0 with a coarse seed of 0x50: needs two iterations to settle at 0x55.
    do_div(16'h0100, 16'h0300, 16'h0050, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL refine_latency got %0d want 6", lat); end
    checks++; if (bus.out_q !== 16'h0055) begin errors++; $display("FAIL refine_q got %h want 0055", bus.out_q); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL refine_ovf got %b want 0", bus.out_ovf); end
    consume();
  endtask

  task automatic test_divzero();
    int lat;
    do_div(16'h1234, 16'h0000, 16'h5555, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (bus.out_q !== 16'hFFFF) begin errors++; $display("FAIL dz_q got %h want FFFF", bus.out_q); end
    checks++; if (bus.out_dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.out_dz); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL dz_ovf got %b want 0", bus.out_ovf); end
    consume();
  endtask

  task automatic test_saturation();
    int lat;
    do_div(16'hFF00, 16'h0080, 16'h0200, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL sat_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (bus.out_q !== 16'hFFFF) begin errors++; $display("FAIL sat_q got %h want FFFF", bus.out_q); end
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", bus.out_ovf); end
    checks++; if (bus.out_dz !== 1'b0) begin errors++; $display("FAIL sat_dz got %b want 0", bus.out_dz); end
    consume();
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_after_consume got %b want 1", bus.out_ovf); end
  endtask

  task automatic test_backpressure();
    int lat;
    // 10.0 / 4.0 with exact seed 0.25 -> 2.5
    do_div(16'h0A00, 16'h0400, 16'h0040, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, EXP_LAT); end
    // Disturb the request inputs while the result is held.
    bus.in_n = 16'h7777;
    bus.in_d = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_q !== 16'h0280) begin errors++; $display("FAIL bp_q[%0d] got %h want 0280", i, bus.out_q); end
      checks++; if ({bus.out_dz, bus.out_ovf} !== 2'b00) begin errors++; $display("FAIL bp_flags[%0d] got %b want 00", i, {bus.out_dz, bus.out_ovf}); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
    end
    // A zero-divisor request offered on the consume edge must not be taken.
    bus.in_valid = 1'b1;
    consume();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_consumed_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_overlap_accept got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midop();
    int lat;
    bus.in_n     = 16'h0600;
    bus.in_d     = 16'h0200;
    seed_f       = 16'h0080;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;  // now in MUL
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got %b want 0", bus.out_valid); end
    do_div(16'h0300, 16'h0100, 16'h0100, lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, EXP_LAT); end
    checks++; if (bus.out_q !== 16'h0300) begin errors++; $display("FAIL midrst_q got %h want 0300", bus.out_q); end
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_n      = '0;
    bus.in_d      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_exact();
    test_refine();
    test_divzero();
    test_saturation();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
